// File: rtl/rdma_xmit_mc_if.sv
// AXI4 slave (AW/W/B/AR/R) plus AXIS data and RDMA header streams for rdma_xmit_mc.
// slave modport is the bridge side; master modport is the AXI master / stream sink side.
interface rdma_xmit_mc_if #(
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int ID_WIDTH       = 4,
    parameter int RDMA_HDR_LEN   = AXI_ADDR_WIDTH + 8 + ID_WIDTH
);
    logic [AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [ID_WIDTH-1:0]         S_AXI_AWID;
    logic [7:0]                  S_AXI_AWLEN;
    logic [2:0]                  S_AXI_AWSIZE;
    logic [1:0]                  S_AXI_AWBURST;
    logic                        S_AXI_AWLOCK;
    logic [3:0]                  S_AXI_AWCACHE;
    logic [3:0]                  S_AXI_AWQOS;
    logic [2:0]                  S_AXI_AWPROT;
    logic                        S_AXI_AWVALID;
    logic                        S_AXI_AWREADY;

    logic [AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                        S_AXI_WLAST;
    logic                        S_AXI_WVALID;
    logic                        S_AXI_WREADY;

    logic [ID_WIDTH-1:0]         S_AXI_BID;
    logic [1:0]                  S_AXI_BRESP;
    logic                        S_AXI_BVALID;
    logic                        S_AXI_BREADY;

    logic [AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [ID_WIDTH-1:0]         S_AXI_ARID;
    logic [7:0]                  S_AXI_ARLEN;
    logic [2:0]                  S_AXI_ARSIZE;
    logic [1:0]                  S_AXI_ARBURST;
    logic                        S_AXI_ARLOCK;
    logic [3:0]                  S_AXI_ARCACHE;
    logic [3:0]                  S_AXI_ARQOS;
    logic [2:0]                  S_AXI_ARPROT;
    logic                        S_AXI_ARVALID;
    logic                        S_AXI_ARREADY;

    logic [AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [ID_WIDTH-1:0]         S_AXI_RID;
    logic [1:0]                  S_AXI_RRESP;
    logic                        S_AXI_RLAST;
    logic                        S_AXI_RVALID;
    logic                        S_AXI_RREADY;

    logic [AXI_DATA_WIDTH-1:0]   AXIS_DATA_TDATA;
    logic [AXI_DATA_WIDTH/8-1:0] AXIS_DATA_TKEEP;
    logic                        AXIS_DATA_TLAST;
    logic                        AXIS_DATA_TVALID;
    logic                        AXIS_DATA_TREADY;

    logic [RDMA_HDR_LEN-1:0]     AXIS_RDMA_TDATA;
    logic                        AXIS_RDMA_TVALID;
    logic                        AXIS_RDMA_TREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
               S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWQOS, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        input  S_AXI_RREADY,
        output AXIS_DATA_TDATA, AXIS_DATA_TKEEP, AXIS_DATA_TLAST, AXIS_DATA_TVALID,
        input  AXIS_DATA_TREADY,
        output AXIS_RDMA_TDATA, AXIS_RDMA_TVALID,
        input  AXIS_RDMA_TREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWID, S_AXI_AWLEN, S_AXI_AWSIZE, S_AXI_AWBURST,
               S_AXI_AWLOCK, S_AXI_AWCACHE, S_AXI_AWQOS, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARID, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
               S_AXI_ARLOCK, S_AXI_ARCACHE, S_AXI_ARQOS, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RID, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID,
        output S_AXI_RREADY,
        input  AXIS_DATA_TDATA, AXIS_DATA_TKEEP, AXIS_DATA_TLAST, AXIS_DATA_TVALID,
        output AXIS_DATA_TREADY,
        input  AXIS_RDMA_TDATA, AXIS_RDMA_TVALID,
        output AXIS_RDMA_TREADY
    );
endinterface

// File: rtl/rdma_xmit_mc.sv
// AXI4 write-to-RDMA bridge: AW -> header stream, W -> data stream, B from a burst table; reads answer SLVERR.
// Latency: AW and W pass through combinationally; B valid the cycle after WLAST; R valid the cycle after AR.
// Backpressure: AWREADY follows header TREADY (blocked when table full), WREADY follows data TREADY.
module rdma_xmit_mc #(
    parameter int AXI_DATA_WIDTH  = 512,
    parameter int AXI_ADDR_WIDTH  = 64,
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 8,
    parameter int RDMA_HDR_LEN    = AXI_ADDR_WIDTH + 8 + ID_WIDTH
) (
    input  logic           clk,
    input  logic           resetn,
    rdma_xmit_mc_if.slave  bus
);
    localparam int IW = $clog2(MAX_OUTSTANDING);
    localparam int PW = IW + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // ------------------------------------------------------------------
    // Write path: burst table with AW / W / B pointers
    // ------------------------------------------------------------------
    logic [ID_WIDTH-1:0] id_tab  [MAX_OUTSTANDING];
    logic [7:0]          len_tab [MAX_OUTSTANDING];
    logic                err_tab [MAX_OUTSTANDING];

    logic [PW-1:0] aw_ptr, w_ptr, b_ptr;
    logic [PW-1:0] outstanding;
    logic [IW-1:0] aw_idx, w_idx, b_idx;
    logic [7:0]    beat_cnt;
    logic          full, w_pending;
    logic          aw_hs, w_hs, b_hs;

    assign aw_idx      = aw_ptr[IW-1:0];
    assign w_idx       = w_ptr[IW-1:0];
    assign b_idx       = b_ptr[IW-1:0];
    assign outstanding = aw_ptr - b_ptr;
    assign full        = (outstanding == PW'(MAX_OUTSTANDING));
    // Registered pointers only: a burst's data cannot move in the cycle its AW is accepted.
    assign w_pending   = (w_ptr != aw_ptr);

    assign bus.AXIS_RDMA_TDATA  = RDMA_HDR_LEN'({bus.S_AXI_AWID, bus.S_AXI_AWLEN, bus.S_AXI_AWADDR});
    assign bus.AXIS_RDMA_TVALID = resetn & bus.S_AXI_AWVALID & ~full;
    assign bus.S_AXI_AWREADY    = resetn & bus.AXIS_RDMA_TREADY & ~full;

    assign bus.AXIS_DATA_TDATA  = bus.S_AXI_WDATA;
    assign bus.AXIS_DATA_TKEEP  = bus.S_AXI_WSTRB;
    assign bus.AXIS_DATA_TLAST  = bus.S_AXI_WLAST;
    assign bus.AXIS_DATA_TVALID = resetn & bus.S_AXI_WVALID & w_pending;
    assign bus.S_AXI_WREADY     = resetn & bus.AXIS_DATA_TREADY & w_pending;

    assign bus.S_AXI_BVALID = resetn & (b_ptr != w_ptr);
    assign bus.S_AXI_BID    = id_tab[b_idx];
    assign bus.S_AXI_BRESP  = err_tab[b_idx] ? RESP_SLVERR : RESP_OKAY;

    assign aw_hs = bus.S_AXI_AWVALID & bus.S_AXI_AWREADY;
    assign w_hs  = bus.S_AXI_WVALID  & bus.S_AXI_WREADY;
    assign b_hs  = bus.S_AXI_BVALID  & bus.S_AXI_BREADY;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            aw_ptr   <= '0;
            w_ptr    <= '0;
            b_ptr    <= '0;
            beat_cnt <= '0;
        end else begin
            if (aw_hs) begin
                aw_ptr <= aw_ptr + PW'(1);
            end
            if (w_hs) begin
                if (bus.S_AXI_WLAST) begin
                    beat_cnt <= '0;
                    w_ptr    <= w_ptr + PW'(1);
                end else begin
                    beat_cnt <= beat_cnt + 8'd1;
                end
            end
            if (b_hs) begin
                b_ptr <= b_ptr + PW'(1);
            end
        end
    end

    // aw_idx and w_idx never alias while both write: equal indices imply empty or full.
    always_ff @(posedge clk) begin
        if (aw_hs) begin
            id_tab[aw_idx]  <= bus.S_AXI_AWID;
            len_tab[aw_idx] <= bus.S_AXI_AWLEN;
            err_tab[aw_idx] <= 1'b0;
        end
        if (w_hs && bus.S_AXI_WLAST) begin
            err_tab[w_idx] <= (beat_cnt != len_tab[w_idx]);
        end
    end

    // ------------------------------------------------------------------
    // Read path: every read burst is answered with zero data and SLVERR
    // ------------------------------------------------------------------
    typedef enum logic {R_IDLE, R_RESP} rstate_t;

    rstate_t             rstate;
    logic                arready_q, rvalid_q, rlast_q;
    logic [7:0]          rcnt, rlen_q;
    logic [ID_WIDTH-1:0] rid_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rstate    <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rcnt      <= '0;
            rlen_q    <= '0;
            rid_q     <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (bus.S_AXI_ARVALID) begin
                        rid_q     <= bus.S_AXI_ARID;
                        rlen_q    <= bus.S_AXI_ARLEN;
                        rcnt      <= '0;
                        rlast_q   <= (bus.S_AXI_ARLEN == 8'd0);
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rstate    <= R_RESP;
                    end
                end
                R_RESP: begin
                    if (bus.S_AXI_RREADY) begin
                        rcnt <= rcnt + 8'd1;
                        if (rlast_q) begin
                            arready_q <= 1'b1;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            rstate    <= R_IDLE;
                        end else begin
                            rlast_q <= ((rcnt + 8'd1) == rlen_q);
                        end
                    end
                end
                default: begin
                    rstate    <= R_IDLE;
                    arready_q <= 1'b1;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.S_AXI_ARREADY = resetn & arready_q;
    assign bus.S_AXI_RVALID  = resetn & rvalid_q;
    assign bus.S_AXI_RLAST   = rlast_q;
    assign bus.S_AXI_RID     = rid_q;
    assign bus.S_AXI_RDATA   = '0;
    assign bus.S_AXI_RRESP   = RESP_SLVERR;

    // AXI attributes the bridge does not interpret.
    logic unused_attr;
    assign unused_attr = ^{bus.S_AXI_AWSIZE, bus.S_AXI_AWBURST, bus.S_AXI_AWLOCK, bus.S_AXI_AWCACHE,
                           bus.S_AXI_AWQOS, bus.S_AXI_AWPROT, bus.S_AXI_ARADDR, bus.S_AXI_ARSIZE,
                           bus.S_AXI_ARBURST, bus.S_AXI_ARLOCK, bus.S_AXI_ARCACHE, bus.S_AXI_ARQOS,
                           bus.S_AXI_ARPROT};
endmodule

// File: tb/tb_rdma_xmit_mc.sv
// Scoreboard bench for rdma_xmit_mc: drivers push expected headers, beats, B and R responses;
// a negedge monitor pops and compares on every output handshake.
module tb_rdma_xmit_mc;
    localparam int DW  = 512;
    localparam int AW  = 64;
    localparam int IDW = 4;
    localparam int HL  = AW + 8 + IDW;
    localparam int KW  = DW / 8;
    localparam int TO  = 3000;

    typedef struct packed {logic [DW-1:0] d; logic [KW-1:0] k; logic l;} beat_t;
    typedef struct packed {logic [IDW-1:0] id; logic [1:0] resp;} bresp_t;
    typedef struct packed {logic [IDW-1:0] id; logic [7:0] len;} burst_t;
    typedef struct packed {logic [IDW-1:0] id; logic last;} rbeat_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    rdma_xmit_mc_if #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .ID_WIDTH(IDW), .RDMA_HDR_LEN(HL)) bus ();

    rdma_xmit_mc #(
        .AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW), .ID_WIDTH(IDW),
        .MAX_OUTSTANDING(8), .RDMA_HDR_LEN(HL)
    ) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    int tests = 0;
    int fails = 0;
    int bp_mode = 0;

    logic [HL-1:0] hdr_q [$];
    beat_t         dat_q [$];
    bresp_t        b_q   [$];
    burst_t        pend_q[$];
    rbeat_t        r_q   [$];

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        tests++;
        fails++;
        $display("FAIL %s: no handshake within %0d cycles", name, TO);
    endtask

    function automatic logic [DW-1:0] rnd_data();
        logic [DW-1:0] v;
        for (int i = 0; i < DW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.AXIS_RDMA_TVALID && bus.AXIS_RDMA_TREADY) begin
                if (hdr_q.size() == 0) check("hdr_unexpected", bus.AXIS_RDMA_TDATA, '1);
                else check("hdr", bus.AXIS_RDMA_TDATA, hdr_q.pop_front());
            end
            if (bus.AXIS_DATA_TVALID && bus.AXIS_DATA_TREADY) begin
                if (dat_q.size() == 0) check("beat_unexpected", bus.AXIS_DATA_TLAST, 2);
                else check("beat", {bus.AXIS_DATA_TDATA, bus.AXIS_DATA_TKEEP, bus.AXIS_DATA_TLAST},
                           dat_q.pop_front());
            end
            if (bus.S_AXI_WVALID || bus.AXIS_DATA_TVALID)
                check("w_axis_hs", bus.S_AXI_WVALID && bus.S_AXI_WREADY,
                      bus.AXIS_DATA_TVALID && bus.AXIS_DATA_TREADY);
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                if (b_q.size() == 0) check("b_unexpected", bus.S_AXI_BID, 16);
                else check("b_resp", {bus.S_AXI_BID, bus.S_AXI_BRESP}, b_q.pop_front());
            end
            if (bus.S_AXI_RVALID && bus.S_AXI_RREADY) begin
                rbeat_t e;
                if (r_q.size() == 0) check("r_unexpected", bus.S_AXI_RID, 16);
                else begin
                    e = r_q.pop_front();
                    check("r_beat", {bus.S_AXI_RDATA, bus.S_AXI_RID, bus.S_AXI_RRESP, bus.S_AXI_RLAST},
                          {{DW{1'b0}}, e.id, 2'b10, e.last});
                end
            end
            if (bus.S_AXI_RVALID || bus.S_AXI_ARREADY)
                check("arready_vs_rvalid", bus.S_AXI_ARREADY, !bus.S_AXI_RVALID);
        end
    end

    // ---------------- ready patterns ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 1) begin
                bus.AXIS_DATA_TREADY = ~bus.AXIS_DATA_TREADY;
            end else if (bp_mode == 2) begin
                bus.AXIS_DATA_TREADY = 1'($urandom_range(0, 1));
                bus.AXIS_RDMA_TREADY = 1'($urandom_range(0, 1));
                bus.S_AXI_BREADY     = 1'($urandom_range(0, 1));
                bus.S_AXI_RREADY     = 1'($urandom_range(0, 1));
            end
        end
    end

    // ---------------- drivers (called at posedge + 1) ----------------
    task automatic aw_send(input logic [IDW-1:0] id, input logic [7:0] len, input logic [AW-1:0] addr);
        int n;
        bit ok;
        bus.S_AXI_AWID    = id;
        bus.S_AXI_AWLEN   = len;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_AWVALID = 1'b1;
        hdr_q.push_back({id, len, addr});
        pend_q.push_back('{id, len});
        n = 0;
        do begin
            @(negedge clk);
            ok = bus.S_AXI_AWREADY;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < TO);
        if (!ok) timeout_fail("aw_timeout");
        bus.S_AXI_AWVALID = 1'b0;
    endtask

    // Sends beats 0..last_pos (WLAST on last_pos), stopping early after nsend beats.
    // The response is SLVERR whenever the beat count differs from len+1.
    task automatic w_send(input burst_t b, input int last_pos, input int nsend);
        int n;
        bit ok;
        beat_t e;
        for (int k = 0; k <= last_pos && k < nsend; k++) begin
            e.d = rnd_data();
            e.k = {$urandom, $urandom};
            e.l = (k == last_pos);
            dat_q.push_back(e);
            bus.S_AXI_WDATA  = e.d;
            bus.S_AXI_WSTRB  = e.k;
            bus.S_AXI_WLAST  = e.l;
            bus.S_AXI_WVALID = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                ok = bus.S_AXI_WREADY;
                @(posedge clk);
                #1;
                n++;
            end while (!ok && n < TO);
            if (!ok) timeout_fail("w_timeout");
        end
        bus.S_AXI_WVALID = 1'b0;
        bus.S_AXI_WLAST  = 1'b0;
        if (last_pos < nsend)
            b_q.push_back('{b.id, (last_pos + 1 == int'(b.len) + 1) ? 2'b00 : 2'b10});
    endtask

    task automatic ar_send(input logic [IDW-1:0] id, input logic [7:0] len);
        int n;
        bit ok;
        for (int i = 0; i <= int'(len); i++) r_q.push_back('{id, (i == int'(len))});
        bus.S_AXI_ARID    = id;
        bus.S_AXI_ARLEN   = len;
        bus.S_AXI_ARADDR  = {$urandom, $urandom};
        bus.S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = bus.S_AXI_ARREADY;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < TO);
        if (!ok) timeout_fail("ar_timeout");
        bus.S_AXI_ARVALID = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((hdr_q.size() + dat_q.size() + b_q.size() + r_q.size()) != 0 && n < TO) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_left"}, hdr_q.size() + dat_q.size() + b_q.size() + r_q.size(), 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"},  bus.S_AXI_AWREADY,    0);
        check({tag, "_wready"},   bus.S_AXI_WREADY,     0);
        check({tag, "_arready"},  bus.S_AXI_ARREADY,    0);
        check({tag, "_bvalid"},   bus.S_AXI_BVALID,     0);
        check({tag, "_rvalid"},   bus.S_AXI_RVALID,     0);
        check({tag, "_hdr_tvld"}, bus.AXIS_RDMA_TVALID, 0);
        check({tag, "_dat_tvld"}, bus.AXIS_DATA_TVALID, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        burst_t b;
        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWID = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWSIZE = 3'd6;
        bus.S_AXI_AWBURST = 2'b01; bus.S_AXI_AWLOCK = 1'b0; bus.S_AXI_AWCACHE = '0;
        bus.S_AXI_AWQOS = '0; bus.S_AXI_AWPROT = '0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARID = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARSIZE = 3'd6;
        bus.S_AXI_ARBURST = 2'b01; bus.S_AXI_ARLOCK = 1'b0; bus.S_AXI_ARCACHE = '0;
        bus.S_AXI_ARQOS = '0; bus.S_AXI_ARPROT = '0;
        bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 1'b0;
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        bus.AXIS_DATA_TREADY = 1'b1; bus.AXIS_RDMA_TREADY = 1'b1;
        // Valids held high through reset: outputs must still stay low.
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_ARVALID = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        check("post_reset_arready", bus.S_AXI_ARREADY, 1);
        @(posedge clk);
        #1;

        // Single burst: header {3,3,0x1000}, four beats, OKAY response.
        aw_send(4'd3, 8'd3, 64'h1000);
        b = pend_q.pop_front();
        w_send(b, 3, 256);
        drain("single");

        // Outstanding limit with BREADY low.
        bus.S_AXI_BREADY = 1'b0;
        for (int i = 0; i < 8; i++) aw_send(IDW'(i), 8'd0, 64'(i) << 12);
        bus.S_AXI_AWID = 4'd8; bus.S_AXI_AWLEN = 8'd0; bus.S_AXI_AWADDR = 64'h8000;
        bus.S_AXI_AWVALID = 1'b1;
        hdr_q.push_back({4'd8, 8'd0, 64'h8000});
        pend_q.push_back('{4'd8, 8'd0});
        repeat (2) begin
            @(negedge clk);
            check("full_awready", bus.S_AXI_AWREADY, 0);
            check("full_hdr_tvalid", bus.AXIS_RDMA_TVALID, 0);
            @(posedge clk);
            #1;
        end
        b = pend_q.pop_front();
        w_send(b, 0, 256);
        check("full_still_blocked", bus.S_AXI_AWREADY, 0);
        bus.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        check("full_b_valid", bus.S_AXI_BVALID, 1);
        @(posedge clk);
        #1;
        bus.S_AXI_BREADY = 1'b0;
        @(negedge clk);
        check("ninth_awready", bus.S_AXI_AWREADY, 1);
        check("ninth_hdr_tvalid", bus.AXIS_RDMA_TVALID, 1);
        @(posedge clk);
        #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_BREADY = 1'b1;
        while (pend_q.size() != 0) begin
            b = pend_q.pop_front();
            w_send(b, 0, 256);
        end
        drain("outstanding");

        // Length error (WLAST on beat 2 of 4), then a correct burst with the same ID.
        aw_send(4'd7, 8'd3, 64'h2000);
        b = pend_q.pop_front();
        w_send(b, 1, 256);
        aw_send(4'd7, 8'd3, 64'h3000);
        b = pend_q.pop_front();
        w_send(b, 3, 256);
        drain("lenerr");

        // Data TREADY toggling every cycle.
        bp_mode = 1;
        for (int i = 0; i < 3; i++) begin
            aw_send(IDW'(i + 10), 8'd7, 64'h4000 + 64'(i));
            b = pend_q.pop_front();
            w_send(b, 7, 256);
        end
        drain("toggle");
        bp_mode = 0;
        #0 bus.AXIS_DATA_TREADY = 1'b1;

        // Read: three SLVERR beats with RID=5.
        ar_send(4'd5, 8'd2);
        drain("read");

        // Reset in the middle of a burst.
        aw_send(4'd9, 8'd3, 64'h5000);
        b = pend_q.pop_front();
        w_send(b, 3, 2);
        bus.S_AXI_WVALID = 1'b1;
        resetn = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        check_idle_outputs("midreset");
        @(posedge clk);
        #1;
        bus.S_AXI_WVALID = 1'b0;
        resetn = 1'b1;
        aw_send(4'd2, 8'd3, 64'h6000);
        b = pend_q.pop_front();
        w_send(b, 3, 256);
        drain("after_reset");

        // Randomised concurrent AW / W / AR traffic with random readies.
        bp_mode = 2;
        fork
            begin
                for (int i = 0; i < 40; i++)
                    aw_send(IDW'($urandom_range(0, 15)), 8'($urandom_range(0, 7)), {$urandom, $urandom});
            end
            begin
                for (int i = 0; i < 40; i++) begin
                    int n;
                    int r;
                    int lp;
                    burst_t wb;
                    n = 0;
                    while (pend_q.size() == 0 && n < TO) begin
                        @(posedge clk);
                        #1;
                        n++;
                    end
                    if (pend_q.size() == 0) begin
                        timeout_fail("rand_w_wait");
                    end else begin
                        wb = pend_q.pop_front();
                        r = $urandom_range(0, 5);
                        if (r == 0 && wb.len > 0) lp = $urandom_range(0, int'(wb.len) - 1);
                        else if (r == 1) lp = int'(wb.len) + 1 + $urandom_range(0, 1);
                        else lp = int'(wb.len);
                        w_send(wb, lp, 256);
                    end
                end
            end
            begin
                for (int i = 0; i < 4; i++) begin
                    ar_send(IDW'($urandom_range(0, 15)), 8'($urandom_range(0, 7)));
                    repeat ($urandom_range(1, 20)) @(posedge clk);
                    #1;
                end
            end
        join
        bp_mode = 0;
        @(posedge clk);
        #2;
        bus.AXIS_DATA_TREADY = 1'b1; bus.AXIS_RDMA_TREADY = 1'b1;
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        drain("random");
        check("pend_left", pend_q.size(), 0);
        @(negedge clk);
        check("final_bvalid", bus.S_AXI_BVALID, 0);
        check("final_arready", bus.S_AXI_ARREADY, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
